// File: rtl/fixed_point_pkg.sv
// rtl/fixed_point_pkg.sv - shared sign-magnitude fixed-point defaults and conversions
//
// Purpose: word-format defaults and sign-magnitude <-> two's-complement helpers
// used by the dense-layer datapath. The helpers work on a 32-bit container and
// take the live word width as an argument, so one pair of functions serves any
// BITSIZE (and any accumulator) up to 32 bits.
package fixed_point_pkg;

  localparam int          BITSIZE_DEF = 16;
  localparam int          FRAC_DEF    = 11;
  localparam logic [14:0] MAG_MAX     = 15'h7FFF;

  // Sign-magnitude word of width 'bits' (zero-extended into 32 bits) to a signed
  // value. Negative zero (sign set, magnitude 0) naturally maps to 0.
  function automatic logic signed [31:0] sm2tc(input logic [31:0] word,
                                               input int unsigned bits);
    logic [31:0] mask;
    logic [31:0] mag;
    mask = (32'd1 << (bits - 1)) - 32'd1;
    mag  = word & mask;
    return word[bits-1] ? -$signed(mag) : $signed(mag);
  endfunction

  // Signed value to a sign-magnitude word of width 'bits', magnitude saturated
  // to all-ones. A zero result always carries sign 0.
  function automatic logic [31:0] tc2sm(input logic signed [31:0] acc,
                                        input int unsigned bits);
    logic [31:0] mask;
    logic [31:0] mag;
    logic [31:0] res;
    mask = (32'd1 << (bits - 1)) - 32'd1;
    mag  = acc[31] ? -acc : acc;
    if (mag > mask) mag = mask;
    res = mag;
    if (acc[31] && (mag != 32'd0)) res = res | (32'd1 << (bits - 1));
    return res;
  endfunction

endpackage

// File: rtl/sm_mult.sv
// rtl/sm_mult.sv - combinational sign-magnitude fixed-point multiplier
//
// Purpose: p = a * b with the magnitude product shifted right by FRAC
// (truncation toward zero) and saturated to the largest magnitude.
// Ports:
//   a_i  BITSIZE  multiplicand, sign-magnitude
//   b_i  BITSIZE  multiplier, sign-magnitude
//   p_o  BITSIZE  product, sign-magnitude, never negative zero
module sm_mult
  import fixed_point_pkg::*;
#(
  parameter int BITSIZE = BITSIZE_DEF,
  parameter int FRAC    = FRAC_DEF
) (
  input  logic [BITSIZE-1:0] a_i,
  input  logic [BITSIZE-1:0] b_i,
  output logic [BITSIZE-1:0] p_o
);

  localparam int MW = BITSIZE - 1;

  logic [2*MW-1:0] full;
  logic [2*MW-1:0] shifted;
  logic [MW-1:0]   mag;

  always_comb begin
    full    = a_i[MW-1:0] * b_i[MW-1:0];
    shifted = full >> FRAC;
    // Anything above the magnitude field means the product overflowed.
    mag     = (|shifted[2*MW-1:MW]) ? {MW{1'b1}} : shifted[MW-1:0];
    // Sign only survives a nonzero magnitude, so 0x8000 inputs and products
    // that truncate to zero both come out as +0.
    p_o     = {(a_i[MW] ^ b_i[MW]) & (|mag), mag};
  end

endmodule

// File: rtl/fc_layer.sv
// rtl/fc_layer.sv - pipelined dense layer y[j] = b[j] + sum_i w[j][i]*x[i]
//
// Purpose: 2-cycle, fully overlapped fully-connected layer in sign-magnitude
// fixed point. Stage 1 registers every saturated product and the biases;
// stage 2 sums each neuron exactly in two's complement and registers the
// saturated sign-magnitude result.
// Ports:
//   clk    1                    rising-edge clock
//   reset  1                    asynchronous active-high, clears both stages
//   x      BITSIZE*N_IN         inputs, element i at x[BITSIZE*i +: BITSIZE]
//   w      BITSIZE*N_IN*N_OUT   weights, w[j][i] at w[BITSIZE*(j*N_IN+i) +: BITSIZE]
//   b      BITSIZE*N_OUT        biases, element j at b[BITSIZE*j +: BITSIZE]
//   y      BITSIZE*N_OUT        outputs, element j at y[BITSIZE*j +: BITSIZE]
module fc_layer
  import fixed_point_pkg::*;
#(
  parameter int BITSIZE = BITSIZE_DEF,
  parameter int FRAC    = FRAC_DEF,
  parameter int N_IN    = 10,
  parameter int N_OUT   = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [BITSIZE*N_IN-1:0]       x,
  input  logic [BITSIZE*N_IN*N_OUT-1:0] w,
  input  logic [BITSIZE*N_OUT-1:0]      b,
  output logic [BITSIZE*N_OUT-1:0]      y
);

  // Worst case is N_IN products plus the bias, each up to full magnitude,
  // plus a sign bit.
  localparam int ACC_W = BITSIZE + $clog2(N_IN + 1) + 1;
  localparam int NP    = N_IN * N_OUT;

  logic [BITSIZE*NP-1:0]    prod_d;
  logic [BITSIZE*NP-1:0]    prod_q;
  logic [BITSIZE*N_OUT-1:0] b_q;
  logic [BITSIZE*N_OUT-1:0] y_d;
  logic [BITSIZE*N_OUT-1:0] y_q;

  // Product k pairs weight k (= j*N_IN + i) with input i = k mod N_IN.
  for (genvar k = 0; k < NP; k++) begin : g_mult
    sm_mult #(
      .BITSIZE(BITSIZE),
      .FRAC   (FRAC)
    ) u_mult (
      .a_i(x[BITSIZE*(k%N_IN) +: BITSIZE]),
      .b_i(w[BITSIZE*k +: BITSIZE]),
      .p_o(prod_d[BITSIZE*k +: BITSIZE])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q <= '0;
      b_q    <= '0;
      y_q    <= '0;
    end else begin
      prod_q <= prod_d;
      b_q    <= b;
      y_q    <= y_d;
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_neuron
    logic signed [ACC_W-1:0] acc;

    always_comb begin
      acc = ACC_W'(sm2tc(32'(b_q[BITSIZE*j +: BITSIZE]), BITSIZE));
      for (int i = 0; i < N_IN; i++) begin
        acc = acc + ACC_W'(sm2tc(32'(prod_q[BITSIZE*(j*N_IN+i) +: BITSIZE]), BITSIZE));
      end
    end

    assign y_d[BITSIZE*j +: BITSIZE] = BITSIZE'(tc2sm(32'(acc), BITSIZE));
  end

  assign y = y_q;

endmodule

// File: tb/tb_fc_layer.sv
// tb/tb_fc_layer.sv - self-checking bench for fc_layer in 10->6, 6->1 and 1->6 form
module tb_fc_layer;

  logic clk;
  logic reset;

  logic [159:0] x_a;  logic [959:0] w_a;  logic [95:0] b_a;  logic [95:0] y_a;
  logic [95:0]  x_b;  logic [95:0]  w_b;  logic [15:0] b_b;  logic [15:0] y_b;
  logic [15:0]  x_c;  logic [95:0]  w_c;  logic [95:0] b_c;  logic [95:0] y_c;

  logic [15:0] xs [3][10];
  logic [15:0] ws [3][6][10];
  logic [15:0] bs [3][6];
  logic [15:0] exp_h [32][3][6];

  int checks = 0;
  int errors = 0;

  fc_layer #(.BITSIZE(16), .FRAC(11), .N_IN(10), .N_OUT(6)) dut_a (
    .clk(clk), .reset(reset), .x(x_a), .w(w_a), .b(b_a), .y(y_a));
  fc_layer #(.BITSIZE(16), .FRAC(11), .N_IN(6), .N_OUT(1)) dut_b (
    .clk(clk), .reset(reset), .x(x_b), .w(w_b), .b(b_b), .y(y_b));
  fc_layer #(.BITSIZE(16), .FRAC(11), .N_IN(1), .N_OUT(6)) dut_c (
    .clk(clk), .reset(reset), .x(x_c), .w(w_c), .b(b_c), .y(y_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    x_a = '0; w_a = '0; b_a = '0;
    for (int i = 0; i < 10; i++) x_a[16*i +: 16] = xs[0][i];
    for (int j = 0; j < 6; j++) begin
      b_a[16*j +: 16] = bs[0][j];
      for (int i = 0; i < 10; i++) w_a[16*(j*10+i) +: 16] = ws[0][j][i];
    end
  end

  always_comb begin
    x_b = '0; w_b = '0;
    for (int i = 0; i < 6; i++) begin
      x_b[16*i +: 16] = xs[1][i];
      w_b[16*i +: 16] = ws[1][0][i];
    end
    b_b = bs[1][0];
  end

  always_comb begin
    w_c = '0; b_c = '0;
    x_c = xs[2][0];
    for (int j = 0; j < 6; j++) begin
      b_c[16*j +: 16] = bs[2][j];
      w_c[16*j +: 16] = ws[2][j][0];
    end
  end

  function automatic int ni_of(input int c);
    case (c)
      0: return 10;
      1: return 6;
      default: return 1;
    endcase
  endfunction

  function automatic int no_of(input int c);
    return (c == 1) ? 1 : 6;
  endfunction

  function automatic longint sval(input logic [15:0] v);
    return v[15] ? -longint'(v[14:0]) : longint'(v[14:0]);
  endfunction

  // Reference: real-valued products truncated and clipped, exact sum, clip.
  function automatic logic [15:0] ref_neuron(input int c, input int j);
    longint acc;
    longint m;
    longint mag;
    logic [15:0] r;
    acc = sval(bs[c][j]);
    for (int i = 0; i < ni_of(c); i++) begin
      m = (longint'(xs[c][i][14:0]) * longint'(ws[c][j][i][14:0])) / 2048;
      if (m > 32767) m = 32767;
      if (xs[c][i][15] != ws[c][j][i][15]) acc = acc - m;
      else acc = acc + m;
    end
    mag = (acc < 0) ? -acc : acc;
    if (mag > 32767) mag = 32767;
    r[15]   = (acc < 0);
    r[14:0] = mag[14:0];
    return r;
  endfunction

  function automatic logic [15:0] get_y(input int c, input int j);
    case (c)
      0: return y_a[16*j +: 16];
      1: return y_b;
      default: return y_c[16*j +: 16];
    endcase
  endfunction

  function automatic logic [15:0] rnd_word();
    logic [15:0] v;
    case ($urandom_range(0, 3))
      0: v[14:0] = 15'($urandom_range(0, 16'h0FFF));
      1: v[14:0] = 15'($urandom_range(0, 16'h7FFF));
      2: v[14:0] = 15'($urandom_range(0, 3));
      default: v[14:0] = 15'($urandom_range(16'h0600, 16'h0A00));
    endcase
    v[15] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
    end
  endtask

  task automatic check_const(input string tag, input int c, input logic [15:0] expv);
    for (int j = 0; j < no_of(c); j++) check($sformatf("%s c%0d y%0d", tag, c, j), get_y(c, j), expv);
  endtask

  task automatic check_model(input string tag, input int c);
    for (int j = 0; j < no_of(c); j++) check($sformatf("%s c%0d y%0d", tag, c, j), get_y(c, j), ref_neuron(c, j));
  endtask

  task automatic set_all(input int c, input logic [15:0] xv, input logic [15:0] wv, input logic [15:0] bv);
    for (int i = 0; i < 10; i++) xs[c][i] = xv;
    for (int j = 0; j < 6; j++) begin
      bs[c][j] = bv;
      for (int i = 0; i < 10; i++) ws[c][j][i] = wv;
    end
  endtask

  task automatic randomize_cfg(input int c);
    for (int i = 0; i < ni_of(c); i++) xs[c][i] = rnd_word();
    for (int j = 0; j < no_of(c); j++) begin
      bs[c][j] = rnd_word();
      for (int i = 0; i < ni_of(c); i++) ws[c][j][i] = rnd_word();
    end
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    for (int c = 0; c < 3; c++) set_all(c, 16'h0000, 16'h0000, 16'h0000);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 3; c++) check_const("reset", c, 16'h0000);
    reset = 1'b0;

    set_all(0, 16'h0800, 16'h0000, 16'h0200);
    settle();
    check_const("bias_pass", 0, 16'h0200);

    set_all(0, 16'h0800, 16'h0400, 16'h0000);
    settle();
    check_const("uniform", 0, 16'h2800);

    set_all(0, 16'h0000, 16'h0400, 16'h0200);
    xs[0][0] = 16'h0800;
    for (int j = 0; j < 6; j++) ws[0][j][0] = 16'h8800;
    settle();
    check_const("sign_pos_bias", 0, 16'h8600);
    for (int j = 0; j < 6; j++) bs[0][j] = 16'h8200;
    settle();
    check_const("sign_neg_bias", 0, 16'h8A00);

    set_all(0, 16'h7800, 16'h7800, 16'h0000);
    settle();
    check_const("sat_pos", 0, 16'h7FFF);
    set_all(0, 16'h7800, 16'hF800, 16'h0000);
    settle();
    check_const("sat_neg", 0, 16'hFFFF);

    set_all(0, 16'h0000, 16'h0400, 16'h8000);
    settle();
    check_const("neg_zero_bias", 0, 16'h0000);
    set_all(0, 16'h0001, 16'h0001, 16'h0000);
    settle();
    check_const("trunc_zero", 0, 16'h0000);
    set_all(0, 16'h8001, 16'h0001, 16'h0000);
    settle();
    check_const("trunc_neg_zero", 0, 16'h0000);

    // One new random vector per cycle on all three layers; each result must
    // show up exactly two edges after its inputs were applied.
    for (int t = 0; t < 26; t++) begin
      if (t >= 2) begin
        for (int c = 0; c < 3; c++)
          for (int j = 0; j < no_of(c); j++)
            check($sformatf("pipe t%0d c%0d y%0d", t - 2, c, j), get_y(c, j), exp_h[t-2][c][j]);
      end
      if (t < 24) begin
        for (int c = 0; c < 3; c++) begin
          randomize_cfg(c);
          for (int j = 0; j < no_of(c); j++) exp_h[t][c][j] = ref_neuron(c, j);
        end
      end
      @(negedge clk);
    end

    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < 3; c++) randomize_cfg(c);
      @(negedge clk);
    end
    for (int c = 0; c < 3; c++) set_all(c, 16'h0800, 16'h0800, 16'h0400);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) check_const("rst_async", c, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 3; c++) check_const("rst_hold", c, 16'h0000);
    for (int c = 0; c < 3; c++) randomize_cfg(c);
    reset = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 3; c++) check_const("rst_rel1", c, 16'h0000);
    @(negedge clk);
    for (int c = 0; c < 3; c++) check_model("rst_rel2", c);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
